// File: rtl/grade_scan_display.sv
// grade_scan_display: accepts a score over a valid/ready handshake, converts it
// to BCD with a sequential double-dabble, and drives a time-multiplexed N-digit
// common-anode 7-seg display. Digit 0 shows the grade letter; digits
// 1..N_DIGITS-1 show ones, tens, ... of the score.
// Optional feature macro: GRADE_BLINK_EN (blink the grade digit while it shows S).
//
// Handshake: score_ready is high only in IDLE; a transfer happens on a rising
// clk edge where score_valid & score_ready. score_valid while score_ready is low
// is ignored and nothing is queued.
module grade_scan_display #(
  parameter int SCORE_W   = 8,
  parameter int N_DIGITS  = 4,
  parameter int SCAN_DIV  = 1000,
  parameter int T_B       = 5,
  parameter int T_A       = 15,
  parameter int T_S       = 21,
  parameter int MAX_SCORE = 25,
  parameter int BLINK_DIV = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [SCORE_W-1:0] score,
  input  logic               score_valid,
  output logic               score_ready,
  output logic [6:0]         seg,
  output logic [N_DIGITS-1:0] an
);

  localparam int BCD_D = N_DIGITS - 1;
  localparam int BCD_W = 4 * BCD_D;
  localparam int PW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int CW    = $clog2(SCORE_W + 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_S     = 7'b0010010;

  typedef enum logic [1:0] {IDLE, CONV, UPDATE} state_t;

  state_t               state;
  logic [SCORE_W-1:0]   sc;
  logic [SCORE_W-1:0]   sh;
  logic [BCD_W-1:0]     bcd;
  logic [BCD_W-1:0]     bcd_adj;
  logic [CW-1:0]        cnt;
  logic [6:0]           pat     [N_DIGITS];
  logic [6:0]           new_pat [N_DIGITS];
  logic [PW-1:0]        presc;
  logic [IW-1:0]        idx;
  logic                 blank_grade;
  logic                 nz;
  logic [3:0]           dig;
  logic                 over;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  // Double-dabble correction: every BCD digit >= 5 gets +3 before the shift.
  always_comb begin
    bcd_adj = bcd;
    for (int j = 0; j < BCD_D; j++) begin
      if (bcd[4*j +: 4] >= 4'd5)
        bcd_adj[4*j +: 4] = bcd[4*j +: 4] + 4'd3;
    end
  end

  // Next display pattern built from the latched score and finished BCD value.
  always_comb begin
    over = (sc > SCORE_W'(MAX_SCORE));
    nz   = 1'b0;
    dig  = 4'd0;
    for (int k = 0; k < N_DIGITS; k++) new_pat[k] = SEG_BLANK;
    if (over)                      new_pat[0] = SEG_BLANK;
    else if (sc >= SCORE_W'(T_S))  new_pat[0] = SEG_S;
    else if (sc >= SCORE_W'(T_A))  new_pat[0] = SEG_A;
    else if (sc >= SCORE_W'(T_B))  new_pat[0] = SEG_B;
    else                           new_pat[0] = SEG_C;
    // Walk from the most significant digit down so leading zeros blank,
    // while the ones digit always shows.
    for (int j = BCD_D - 1; j >= 0; j--) begin
      dig = bcd[4*j +: 4];
      if (dig != 4'd0) nz = 1'b1;
      if (over)                new_pat[j+1] = SEG_DASH;
      else if (nz || (j == 0)) new_pat[j+1] = seg7(dig);
      else                     new_pat[j+1] = SEG_BLANK;
    end
  end

  // Control FSM: accept, shift-add-3 for SCORE_W cycles, load display atomically.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      score_ready <= 1'b1;
      sc          <= '0;
      sh          <= '0;
      bcd         <= '0;
      cnt         <= '0;
      for (int k = 0; k < N_DIGITS; k++) pat[k] <= SEG_BLANK;
    end else begin
      case (state)
        IDLE: begin
          if (score_valid && score_ready) begin
            sc          <= score;
            sh          <= score;
            bcd         <= '0;
            cnt         <= '0;
            score_ready <= 1'b0;
            state       <= CONV;
          end
        end
        CONV: begin
          bcd <= {bcd_adj[BCD_W-2:0], sh[SCORE_W-1]};
          sh  <= sh << 1;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(SCORE_W - 1)) state <= UPDATE;
        end
        UPDATE: begin
          for (int k = 0; k < N_DIGITS; k++) pat[k] <= new_pat[k];
          score_ready <= 1'b1;
          state       <= IDLE;
        end
        default: begin
          score_ready <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

`ifdef GRADE_BLINK_EN
  localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  logic [FW-1:0] frame_cnt;
  logic          phase;

  // Frame counter: toggles blink phase every BLINK_DIV complete scan frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      phase     <= 1'b0;
    end else if ((presc == PW'(SCAN_DIV - 1)) && (idx == IW'(N_DIGITS - 1))) begin
      if (frame_cnt == FW'(BLINK_DIV - 1)) begin
        frame_cnt <= '0;
        phase     <= ~phase;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  assign blank_grade = (pat[0] == SEG_S) && !phase;
`else
  assign blank_grade = 1'b0;
`endif

  // Scan: prescaler steps the digit index; an and seg register together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      idx   <= '0;
      an    <= '1;
      seg   <= SEG_BLANK;
    end else begin
      if (presc == PW'(SCAN_DIV - 1)) begin
        presc <= '0;
        idx   <= (idx == IW'(N_DIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
        presc <= presc + 1'b1;
      end
      an  <= ~(N_DIGITS'(1) << idx);
      seg <= ((idx == '0) && blank_grade) ? SEG_BLANK : pat[idx];
    end
  end

endmodule

// File: tb/tb_grade_scan_display.sv
// Directed bench for grade_scan_display with SCAN_DIV=4, N_DIGITS=4, SCORE_W=8.
module tb_grade_scan_display;

  localparam logic [6:0] G_C  = 7'b1000110;
  localparam logic [6:0] G_B  = 7'b0000011;
  localparam logic [6:0] G_A  = 7'b0001000;
  localparam logic [6:0] G_S  = 7'b0010010;
  localparam logic [6:0] BL   = 7'b1111111;
  localparam logic [6:0] DASH = 7'b0111111;
  localparam logic [6:0] D0   = 7'b1000000;
  localparam logic [6:0] D2   = 7'b0100100;
  localparam logic [6:0] D4   = 7'b0011001;
  localparam logic [6:0] D5   = 7'b0010010;

  // clock / reset
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] score = '0;
  logic       score_valid = 1'b0;
  logic       score_ready;
  logic [6:0] seg;
  logic [3:0] an;

  int n_tests = 0;
  int n_fail  = 0;
  logic [6:0] got [4];
  logic [6:0] exp_p [4];

  always #5 clk = ~clk;

  grade_scan_display #(
    .SCORE_W(8), .N_DIGITS(4), .SCAN_DIV(4), .T_B(5), .T_A(15),
    .T_S(21), .MAX_SCORE(25), .BLINK_DIV(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .score(score), .score_valid(score_valid),
    .score_ready(score_ready), .seg(seg), .an(an)
  );

  // driver tasks
  task automatic wait_ready();
    int i;
    i = 0;
    @(negedge clk);
    while (score_ready !== 1'b1 && i < 200) begin
      @(negedge clk);
      i++;
    end
    if (score_ready !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_ready: score_ready=%b after %0d cycles, required 1", score_ready, i);
    end
  endtask

  task automatic send_score(input logic [7:0] v, output int busy);
    wait_ready();
    score = v;
    score_valid = 1'b1;
    @(posedge clk);
    #1;
    score_valid = 1'b0;
    busy = 0;
    while (score_ready !== 1'b1 && busy < 100) begin
      busy++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic read_digit(input int k, output logic [6:0] s);
    logic [3:0] want;
    want = ~(4'b0001 << k);
    s = 'x;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (an === want) begin
        s = seg;
        break;
      end
    end
  endtask

  task automatic read_all();
    repeat (2) @(posedge clk);
    for (int k = 0; k < 4; k++) read_digit(k, got[k]);
  endtask

  task automatic test_reset();
    logic [3:0] want;
    rst_n = 1'b0;
    score_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (seg !== BL) begin n_fail++; $display("FAIL reset_seg: got %b required %b", seg, BL); end
    n_tests++; if (an !== 4'b1111) begin n_fail++; $display("FAIL reset_an: got %b required 1111", an); end
    n_tests++; if (score_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b required 1", score_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      want = ~(4'b0001 << k);
      @(posedge clk);
      #1;
      n_tests++; if (an !== want) begin n_fail++; $display("FAIL scan_an%0d: got %b required %b", k, an, want); end
      n_tests++; if (seg !== BL) begin n_fail++; $display("FAIL scan_seg%0d: got %b required %b", k, seg, BL); end
      repeat (3) @(posedge clk);
    end
  endtask

  task automatic test_convert();
    int busy;
    send_score(8'd4, busy);
    n_tests++; if (busy !== 9) begin n_fail++; $display("FAIL busy_cycles: got %0d required 9", busy); end
    read_all();
    exp_p[0] = G_C; exp_p[1] = D4; exp_p[2] = BL; exp_p[3] = BL;
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (got[k] !== exp_p[k]) begin n_fail++; $display("FAIL score4_digit%0d: got %b required %b", k, got[k], exp_p[k]); end
    end
  endtask

  task automatic test_boundaries();
    logic [7:0] sv [7];
    logic [6:0] gv [7];
    int busy;
    sv[0] = 4;  sv[1] = 5;  sv[2] = 14; sv[3] = 15; sv[4] = 20; sv[5] = 21; sv[6] = 25;
    gv[0] = G_C; gv[1] = G_B; gv[2] = G_B; gv[3] = G_A; gv[4] = G_A; gv[5] = G_S; gv[6] = G_S;
    for (int i = 0; i < 7; i++) begin
      send_score(sv[i], busy);
      read_all();
      n_tests++;
      if (got[0] !== gv[i]) begin n_fail++; $display("FAIL grade_%0d: got %b required %b", sv[i], got[0], gv[i]); end
      if (sv[i] == 8'd25) begin
        n_tests++; if (got[1] !== D5) begin n_fail++; $display("FAIL s25_ones: got %b required %b", got[1], D5); end
        n_tests++; if (got[2] !== D2) begin n_fail++; $display("FAIL s25_tens: got %b required %b", got[2], D2); end
      end
    end
  endtask

  task automatic test_overflow();
    int busy;
    send_score(8'd26, busy);
    read_all();
    exp_p[0] = BL; exp_p[1] = DASH; exp_p[2] = DASH; exp_p[3] = DASH;
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (got[k] !== exp_p[k]) begin n_fail++; $display("FAIL over26_digit%0d: got %b required %b", k, got[k], exp_p[k]); end
    end
    send_score(8'd0, busy);
    read_all();
    exp_p[0] = G_C; exp_p[1] = D0; exp_p[2] = BL; exp_p[3] = BL;
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (got[k] !== exp_p[k]) begin n_fail++; $display("FAIL zero_digit%0d: got %b required %b", k, got[k], exp_p[k]); end
    end
  endtask

  task automatic test_busy_ignore();
    wait_ready();
    score = 8'd25;
    score_valid = 1'b1;
    @(posedge clk);
    #1;
    score_valid = 1'b0;
    @(negedge clk);
    n_tests++; if (score_ready !== 1'b0) begin n_fail++; $display("FAIL busy_ready: got %b required 0", score_ready); end
    score = 8'd3;
    score_valid = 1'b1;
    @(negedge clk);
    score_valid = 1'b0;
    wait_ready();
    read_all();
    exp_p[0] = G_S; exp_p[1] = D5; exp_p[2] = D2; exp_p[3] = BL;
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (got[k] !== exp_p[k]) begin n_fail++; $display("FAIL ignore_digit%0d: got %b required %b", k, got[k], exp_p[k]); end
    end
  endtask

  task automatic test_reset_mid_conv();
    wait_ready();
    score = 8'd4;
    score_valid = 1'b1;
    @(posedge clk);
    #1;
    score_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++; if (seg !== BL) begin n_fail++; $display("FAIL midrst_seg: got %b required %b", seg, BL); end
    n_tests++; if (an !== 4'b1111) begin n_fail++; $display("FAIL midrst_an: got %b required 1111", an); end
    n_tests++; if (score_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b required 1", score_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    n_tests++; if (score_ready !== 1'b1) begin n_fail++; $display("FAIL postrst_ready: got %b required 1", score_ready); end
    read_all();
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (got[k] !== BL) begin n_fail++; $display("FAIL postrst_digit%0d: got %b required %b", k, got[k], BL); end
    end
  endtask

`ifdef GRADE_BLINK_EN
  task automatic test_blink();
    int busy;
    int n_bl;
    int n_s;
    logic [6:0] s;
    send_score(8'd21, busy);
    n_bl = 0;
    n_s = 0;
    for (int f = 0; f < 8; f++) begin
      read_digit(0, s);
      if (s === BL) n_bl++;
      else if (s === G_S) n_s++;
      else begin
        n_tests++; n_fail++;
        $display("FAIL blink_value: got %b required %b or %b", s, BL, G_S);
      end
    end
    n_tests++; if (n_bl < 2) begin n_fail++; $display("FAIL blink_off_frames: got %0d required >=2", n_bl); end
    n_tests++; if (n_s < 2) begin n_fail++; $display("FAIL blink_on_frames: got %0d required >=2", n_s); end
    send_score(8'd20, busy);
    repeat (2) @(posedge clk);
    for (int f = 0; f < 6; f++) begin
      read_digit(0, s);
      n_tests++;
      if (s !== G_A) begin n_fail++; $display("FAIL steady_a%0d: got %b required %b", f, s, G_A); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_convert();
    test_boundaries();
    test_overflow();
    test_busy_ignore();
    test_reset_mid_conv();
`ifdef GRADE_BLINK_EN
    test_blink();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
